mem_line_ctrl: RTL

- Memory-side responder for the data cache's line-refill/write-back port.
- Accepts one 128-bit line request at a time: read (refill) or write (write-back).
- Converts each request into four 32-bit beats on a word-wide RAM port.
- Returns a one-cycle ready pulse, plus the assembled line on reads; sits between the D-cache and main memory.

---
 rtl/mem_line_ctrl_pkg.sv | 30 +++
 rtl/mem_line_ctrl_if.sv | 31 +++
 rtl/mem_line_ctrl_timer.sv | 37 +++
 rtl/mem_line_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_line_ctrl_pkg.sv
// Shared types and geometry for the D-cache line-refill / write-back responder.
// The beat helpers map a line address and a beat index onto the word-wide RAM port.
package mem_line_ctrl_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int OFFSET_W   = 4;
  localparam int ADDR_W     = 32;
  localparam int BEAT_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_TURN
  } state_e;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:OFFSET_W] line,
                                                  input logic [BEAT_W-1:0]        beat);
    return {line, beat, 2'b00};
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] beat);
    return line[WORD_W*int'(beat) +: WORD_W];
  endfunction

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Cache-side line request bus plus word-wide RAM port of mem_line_ctrl.
// slave is the controller's view; master is the cache/RAM environment's view.
interface mem_line_ctrl_if;
  import mem_line_ctrl_pkg::*;

  logic              req_r;
  logic              req_w;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              req_ready;
  logic [LINE_W-1:0] req_rdata;
  logic              req_err;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  req_r, req_w, req_addr, req_wdata, ram_rdata, ram_ack,
    output req_ready, req_rdata, req_err, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_r, req_w, req_addr, req_wdata, ram_rdata, ram_ack,
    input  req_ready, req_rdata, req_err, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_line_ctrl_timer.sv
// Per-beat RAM wait counter; expired_o rises once TIMEOUT unacknowledged cycles have elapsed.
// TO_W must be wide enough that 2**TO_W > TIMEOUT.
module mem_beat_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TO_W'(TIMEOUT));

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// Memory-side responder: turns one 128-bit line read/write into four 32-bit RAM beats,
// then pulses req_ready (with req_err on a per-beat timeout) and idles one TURN cycle.
module mem_line_ctrl
  import mem_line_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_line_ctrl_if.slave bus
);

  state_e                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDR_W-1:OFFSET_W]  line_q, line_d;
  logic [LINE_W-1:0]         wdata_q, wdata_d;
  logic [LINE_W-1:0]         rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic                      timer_clr;
  logic                      timer_en;
  logic                      expired;

  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic [WORD_W-1:0]         ram_wdata;
  logic                      req_ready;
  logic                      req_err;

  logic                      unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[OFFSET_W-1:0];

  mem_beat_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clr),
    .count_en_i (timer_en),
    .expired_o  (expired)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    req_ready = 1'b0;
    req_err   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        err_d  = 1'b0;
        if (bus.req_w) begin
          line_d  = bus.req_addr[ADDR_W-1:OFFSET_W];
          wdata_d = bus.req_wdata;
          state_d = ST_WRITE;
        end else if (bus.req_r) begin
          line_d  = bus.req_addr[ADDR_W-1:OFFSET_W];
          state_d = ST_READ;
        end
      end

      ST_WRITE, ST_READ: begin
        if (expired) begin
          // Abort: ram_en is already low this cycle; unfilled read slots stay as they were.
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_clr = 1'b0;
          ram_en    = 1'b1;
          ram_we    = (state_q == ST_WRITE);
          ram_addr  = beat_addr(line_q, beat_q);
          if (state_q == ST_WRITE) begin
            ram_wdata = line_word(wdata_q, beat_q);
          end
          if (bus.ram_ack) begin
            timer_clr = 1'b1;
            beat_d    = beat_q + 1'b1;
            if (state_q == ST_READ) begin
              rdata_d[WORD_W*int'(beat_q) +: WORD_W] = bus.ram_rdata;
            end
            if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
              state_d = ST_RESP;
            end
          end else begin
            timer_en = 1'b1;
          end
        end
      end

      ST_RESP: begin
        req_ready = 1'b1;
        req_err   = err_q;
        state_d   = ST_TURN;
      end

      // The cache drops its request one cycle after req_ready; ignore it here.
      ST_TURN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the read buffer is reset too, because req_rdata must read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.req_ready = req_ready;
  assign bus.req_err   = req_err;
  assign bus.req_rdata = rdata_q;

endmodule
